// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 32-bit 4:1 mux.
// Each grant lasts until the requester drops or MAX_BEATS beats have been accepted.
//
// state | meaning
// IDLE  | no owner; arbitrate among req starting after the last owner
// GRANT | requester sel owns the mux; beats counted until release
module mux4_rr_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic [3:0] accept,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [3:0]       grant_nxt;
    logic [1:0]       sel_nxt;
    logic [1:0]       last, last_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic             beat_fire;
    logic             final_beat;

    // Search order starts one past the previous owner so every requester gets a turn.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand   = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign busy       = (state == GRANT);
    assign out_valid  = busy & req[sel];
    assign beat_fire  = out_valid & out_ready;
    assign accept     = grant & {4{beat_fire}};
    assign final_beat = beat_fire & (beat_cnt == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        sel_nxt      = sel;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    grant_nxt    = 4'b0001 << winner;
                    sel_nxt      = winner;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!req[sel] || final_beat) begin
                    state_nxt    = IDLE;
                    grant_nxt    = '0;
                    last_nxt     = sel;
                    beat_cnt_nxt = '0;
                end else if (beat_fire) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                grant_nxt    = '0;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= 2'b00;
            last     <= 2'd3;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule
